// File: rtl/register_file.sv
// Integer register file with combinational reads, write-through bypass and a
// pending-write scoreboard that raises an ID-stage hazard stall.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wb_reg_write,
  input  logic [AW-1:0]    i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic [AW-1:0]    i_id_rs1,
  input  logic [AW-1:0]    i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_issue,
  input  logic             i_id_writes_rd,
  input  logic [AW-1:0]    i_id_rd,
  input  logic             i_kill_valid,
  input  logic [AW-1:0]    i_kill_rd,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data,
  output logic             o_id_stall,
  output logic [NREGS-1:0] o_busy
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic             wb_en;
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] kill_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] busy_eff;
  logic             stall;

  assign wb_en = i_wb_reg_write && (i_wb_rd != '0);

  always_comb begin
    wb_mask   = '0;
    kill_mask = '0;
    if (wb_en) wb_mask[i_wb_rd] = 1'b1;
    if (i_kill_valid && (i_kill_rd != '0)) kill_mask[i_kill_rd] = 1'b1;
  end

  // A register being written back this cycle is covered by the bypass,
  // so it no longer counts as a hazard for the instruction in ID.
  assign busy_eff = busy_q & ~wb_mask;

  always_comb begin
    stall = (i_id_use_rs1   && busy_eff[i_id_rs1]) ||
            (i_id_use_rs2   && busy_eff[i_id_rs2]) ||
            (i_id_writes_rd && busy_eff[i_id_rd]);
  end

  always_comb begin
    set_mask = '0;
    if (i_id_issue && i_id_writes_rd && (i_id_rd != '0) && !stall)
      set_mask[i_id_rd] = 1'b1;
  end

  // Set is applied last so a newly issued producer wins over a clear/kill.
  always_comb begin
    busy_d    = (busy_q & ~wb_mask & ~kill_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (wb_en) regs_d[i_wb_rd] = i_wb_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  always_comb begin
    o_rs1_data = regs_q[i_id_rs1];
    o_rs2_data = regs_q[i_id_rs2];
    if (wb_en && (i_wb_rd == i_id_rs1)) o_rs1_data = i_wb_data;
    if (wb_en && (i_wb_rd == i_id_rs2)) o_rs2_data = i_wb_data;
  end

  assign o_id_stall = stall;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// run against an array-based reference model of registers and pending writes.
module tb_register_file;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      id_rs1, id_rs2, id_rd, kill_rd;
  logic            id_use_rs1, id_use_rs2, id_issue, id_writes_rd, kill_valid;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            id_stall;
  logic [NREGS-1:0] busy;

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_reg_write(wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_id_issue(id_issue), .i_id_writes_rd(id_writes_rd), .i_id_rd(id_rd),
    .i_kill_valid(kill_valid), .i_kill_rd(kill_rd),
    .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
    .o_id_stall(id_stall), .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // reference model: architectural registers and pending-write flags
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  function automatic bit m_hazard(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (wb_reg_write && wb_rd == r) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic bit m_stall();
    return (id_use_rs1 && m_hazard(id_rs1)) || (id_use_rs2 && m_hazard(id_rs2)) ||
           (id_writes_rd && m_hazard(id_rd));
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [4:0] r);
    if (r == 0) return '0;
    if (wb_reg_write && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic logic [NREGS-1:0] m_busy_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Evaluate the model for the upcoming edge from the inputs now applied.
  task automatic m_edge();
    bit st;
    st = m_stall();
    if (wb_reg_write && wb_rd != 0) begin
      m_regs[wb_rd] = wb_data;
      m_busy[wb_rd] = 1'b0;
    end
    if (kill_valid && kill_rd != 0) m_busy[kill_rd] = 1'b0;
    if (id_issue && id_writes_rd && id_rd != 0 && !st) m_busy[id_rd] = 1'b1;
  endtask

  // driver tasks
  task automatic idle();
    wb_reg_write = 0; wb_rd = 0; wb_data = '0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_issue = 0; id_writes_rd = 0; id_rd = 0;
    kill_valid = 0; kill_rd = 0;
  endtask

  task automatic drive_phase();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    m_reset();
    #12;
    id_rs1 = 5'd7; id_rs2 = 5'd31; id_use_rs1 = 1; id_use_rs2 = 1;
    id_writes_rd = 1; id_rd = 5'd3;
    #1;
    checks++;
    if (busy !== '0) begin
      errors++; $display("FAIL reset_busy got %h want 0", busy);
    end
    checks++;
    if (rs1_data !== '0 || rs2_data !== '0) begin
      errors++; $display("FAIL reset_read got %h/%h want 0/0", rs1_data, rs2_data);
    end
    checks++;
    if (id_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b want 0", id_stall);
    end
    drive_phase();
    rst = 0;
    idle();
  endtask

  task automatic test_write_read();
    drive_phase();
    wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    drive_phase();
    idle();
    wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'h00001234;
    id_rs1 = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_x5 got %h want deadbeef", rs1_data);
    end
    step();
    drive_phase();
    idle();
    id_rs2 = 5'd0;
    #1;
    checks++;
    if (rs2_data !== 32'h0) begin
      errors++; $display("FAIL read_x0 got %h want 00000000", rs2_data);
    end
  endtask

  task automatic test_bypass();
    drive_phase();
    idle();
    wb_reg_write = 1; wb_rd = 5'd7; wb_data = 32'hA5A5A5A5;
    id_rs1 = 5'd7; id_rs2 = 5'd7;
    #1;
    checks++;
    if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_x7 got %h/%h want a5a5a5a5", rs1_data, rs2_data);
    end
    step();
    drive_phase();
    idle();
  endtask

  task automatic test_stall();
    drive_phase();
    idle();
    id_issue = 1; id_writes_rd = 1; id_rd = 5'd3;
    step();
    checks++;
    if (busy !== 32'h0000_0008) begin
      errors++; $display("FAIL issue_x3_busy got %h want 00000008", busy);
    end
    for (int c = 0; c < 3; c++) begin
      drive_phase();
      idle();
      id_rs1 = 5'd3; id_use_rs1 = 1; id_issue = 1;
      #1;
      checks++;
      if (id_stall !== 1'b1) begin
        errors++; $display("FAIL raw_stall_%0d got %b want 1", c, id_stall);
      end
      step();
    end
    drive_phase();
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'h1357_9BDF;
    #1;
    checks++;
    if (id_stall !== 1'b0 || rs1_data !== 32'h1357_9BDF) begin
      errors++; $display("FAIL wb_release got stall=%b data=%h want 0/13579bdf", id_stall, rs1_data);
    end
    step();
    checks++;
    if (busy !== '0) begin
      errors++; $display("FAIL wb_clear_busy got %h want 0", busy);
    end
    drive_phase();
    idle();
  endtask

  task automatic test_set_wins();
    drive_phase();
    idle();
    id_issue = 1; id_writes_rd = 1; id_rd = 5'd9;
    step();
    drive_phase();
    idle();
    wb_reg_write = 1; wb_rd = 5'd9; wb_data = 32'h0000_0009;
    id_issue = 1; id_writes_rd = 1; id_rd = 5'd9;
    step();
    checks++;
    if (busy !== 32'h0000_0200) begin
      errors++; $display("FAIL set_wins got %h want 00000200", busy);
    end
    drive_phase();
    idle();
    kill_valid = 1; kill_rd = 5'd9;
    step();
    checks++;
    if (busy !== '0) begin
      errors++; $display("FAIL kill_x9 got %h want 0", busy);
    end
    // busy x11, x12 then set x10 / clear x11 / kill x12 in one edge
    drive_phase();
    idle();
    id_issue = 1; id_writes_rd = 1; id_rd = 5'd11;
    step();
    drive_phase();
    id_rd = 5'd12;
    step();
    drive_phase();
    idle();
    id_issue = 1; id_writes_rd = 1; id_rd = 5'd10;
    wb_reg_write = 1; wb_rd = 5'd11; wb_data = 32'h11;
    kill_valid = 1; kill_rd = 5'd12;
    step();
    checks++;
    if (busy !== 32'h0000_0400) begin
      errors++; $display("FAIL multi_update got %h want 00000400", busy);
    end
    drive_phase();
    idle();
    kill_valid = 1; kill_rd = 5'd10;
    step();
    drive_phase();
    idle();
  endtask

  task automatic test_x0();
    drive_phase();
    idle();
    id_issue = 1; id_writes_rd = 1; id_rd = 5'd0;
    step();
    checks++;
    if (busy !== '0) begin
      errors++; $display("FAIL issue_x0 got %h want 0", busy);
    end
    drive_phase();
    idle();
    id_rs1 = 5'd0; id_use_rs1 = 1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++; $display("FAIL use_x0_stall got %b want 0", id_stall);
    end
    drive_phase();
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_phase();
      wb_reg_write = ($urandom_range(0, 2) != 0);
      wb_rd        = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      id_issue     = 1'($urandom_range(0, 1));
      id_writes_rd = 1'($urandom_range(0, 1));
      id_rd        = 5'($urandom_range(0, 7));
      kill_valid   = ($urandom_range(0, 5) == 0);
      kill_rd      = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (rs1_data !== m_read(id_rs1) || rs2_data !== m_read(id_rs2)) begin
        errors++;
        $display("FAIL rand_read_%0d got %h/%h want %h/%h", n, rs1_data, rs2_data,
                 m_read(id_rs1), m_read(id_rs2));
      end
      checks++;
      if (id_stall !== m_stall()) begin
        errors++; $display("FAIL rand_stall_%0d got %b want %b", n, id_stall, m_stall());
      end
      step();
      checks++;
      if (busy !== m_busy_vec()) begin
        errors++; $display("FAIL rand_busy_%0d got %h want %h", n, busy, m_busy_vec());
      end
    end
    drive_phase();
    idle();
  endtask

  task automatic test_async_reset();
    drive_phase();
    idle();
    wb_reg_write = 1; wb_rd = 5'd1; wb_data = 32'hCAFE0001;
    step();
    drive_phase();
    wb_rd = 5'd2; wb_data = 32'hCAFE0002;
    step();
    drive_phase();
    idle();
    id_issue = 1; id_writes_rd = 1; id_rd = 5'd1;
    step();
    drive_phase();
    id_rd = 5'd2;
    step();
    checks++;
    if (busy !== 32'h0000_0006) begin
      errors++; $display("FAIL pre_reset_busy got %h want 00000006", busy);
    end
    drive_phase();
    idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2;
    #1;
    rst = 1;
    #1;
    m_reset();
    checks++;
    if (busy !== '0 || rs1_data !== '0 || rs2_data !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%h rd=%h/%h want 0/0/0", busy, rs1_data, rs2_data);
    end
    rst = 0;
    #1;
    id_issue = 1; id_writes_rd = 1; id_rd = 5'd1; id_use_rs1 = 1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++; $display("FAIL post_reset_stall got %b want 0", id_stall);
    end
    step();
    checks++;
    if (busy !== 32'h0000_0002) begin
      errors++; $display("FAIL post_reset_busy got %h want 00000002", busy);
    end
    drive_phase();
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_stall();
    test_set_wins();
    test_x0();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 The block SHALL have parameter NREGS, default 32, register count (address width $clog2(NREGS)=5).
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_wb_reg_write, input, 1, write-back enable from the WB stage.
REQ-006 The block SHALL have port i_wb_rd, input, 5, write-back destination register.
REQ-007 The block SHALL have port i_wb_data, input, XLEN, write-back data (final WB mux output).
REQ-008 The block SHALL have ports i_id_rs1 and i_id_rs2, input, 5 each, decode-stage source register addresses.
REQ-009 The block SHALL have ports i_id_use_rs1 and i_id_use_rs2, input, 1 each, source actually consumed by the decoded instruction.
REQ-010 The block SHALL have port i_id_issue, input, 1, decoded instruction leaves ID this cycle.
REQ-011 The block SHALL have ports i_id_writes_rd (input, 1) and i_id_rd (input, 5), issuing instruction's destination.
REQ-012 The block SHALL have ports i_kill_valid (input, 1) and i_kill_rd (input, 5), squashed in-flight producer whose pending write is cancelled.
REQ-013 The block SHALL have ports o_rs1_data and o_rs2_data, output, XLEN each, read data.
REQ-014 The block SHALL have port o_id_stall, output, 1, hazard stall request to ID.
REQ-015 The block SHALL have port o_busy, output, NREGS, pending-write scoreboard bits.

Function
REQ-016 Storage SHALL be NREGS x XLEN flops; register 0 SHALL never be written and SHALL always read 0.
REQ-017 On a rising edge with i_wb_reg_write=1 and i_wb_rd!=0, regs[i_wb_rd] SHALL take i_wb_data.
REQ-018 Reads SHALL be combinational (zero latency) from rs1/rs2 addresses.
REQ-019 Write-through bypass: if i_wb_reg_write=1, i_wb_rd!=0 and i_wb_rd equals a read address, that read port SHALL output i_wb_data in the same cycle.
REQ-020 Scoreboard SHALL hold busy[NREGS-1:0]; busy[0] SHALL be constant 0.
REQ-021 Set: on an edge with i_id_issue=1, i_id_writes_rd=1, i_id_rd!=0, busy[i_id_rd] SHALL become 1.
REQ-022 Clear: on an edge with i_wb_reg_write=1, i_wb_rd!=0, busy[i_wb_rd] SHALL become 0.
REQ-023 Kill: on an edge with i_kill_valid=1, i_kill_rd!=0, busy[i_kill_rd] SHALL become 0.
REQ-024 Simultaneous set and clear/kill of the same register SHALL resolve with set winning (newer producer).
REQ-025 Set, clear and kill of different registers in one cycle SHALL all take effect.
REQ-026 o_id_stall SHALL be combinational: 1 when (i_id_use_rs1 and busy[rs1]) or (i_id_use_rs2 and busy[rs2]) or (i_id_writes_rd and busy[i_id_rd]), excluding register 0.
REQ-027 A source whose busy bit is being cleared by a write-back in the same cycle SHALL NOT cause a stall (bypass covers it).
REQ-028 While o_id_stall=1, an asserted i_id_issue SHALL be ignored (no busy set).
REQ-029 o_busy SHALL reflect registered busy state (no same-cycle update).

Reset
REQ-030 While i_rst=1, all registers and all busy bits SHALL be 0, asynchronously, regardless of i_clk.
REQ-031 While i_rst=1, o_rs1_data/o_rs2_data SHALL be 0 except under same-cycle bypass, o_busy SHALL be 0, o_id_stall SHALL be 0 and writes SHALL be ignored.
REQ-032 Reset asserted mid-operation SHALL discard all pending busy bits; first edge after deassertion SHALL behave as from empty state.

Verification
REQ-033 Write x5=0xDEADBEEF, next cycle read rs1=5 -> o_rs1_data=0xDEADBEEF; write x0=0x1234 -> rs2=0 reads 0x00000000.
REQ-034 Same cycle write x7=0xA5A5A5A5 and read rs1=rs2=7 -> both ports 0xA5A5A5A5 that cycle.
REQ-035 Issue rd=3, then ID uses rs1=3 -> o_id_stall=1 until WB writes x3; in WB cycle stall=0 and o_rs1_data=WB data.
REQ-036 Same edge: WB clears x9 and issue sets x9 -> o_busy[9]=1 after edge; kill x9 -> o_busy[9]=0.
REQ-037 Issue rd=0 -> o_busy stays 0x00000000; ID rs1=0 with use -> no stall.
REQ-038 Set busy bits x1,x2, regs nonzero, pulse i_rst between clock edges -> o_busy=0 and all reads 0 immediately.
